// File: rtl/bist_pkg.sv
// Shared definitions for the full-adder BIST loop: FSM states, MISR
// polynomial, default golden signature and the MISR next-state helper.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bistState_e;

    // x^8 + x^4 + x^3 + x^2 + 1 (the x^8 term is implied by the shift-out)
    localparam logic [7:0] MISR_POLY      = 8'h1D;
    // Final signature of a fault-free full adder over the exhaustive pattern set
    localparam logic [7:0] DEFAULT_GOLDEN = 8'h47;

    // One MISR step: shift left, fold the shifted-out bit back through the
    // polynomial, then mix the 2-bit response into the low bits.
    function automatic logic [7:0] misrStep(input logic [7:0] cur, input logic [1:0] din);
        logic [7:0] fbTerm;
        fbTerm   = cur[7] ? MISR_POLY : 8'h00;
        misrStep = {cur[6:0], 1'b0} ^ fbTerm ^ {6'b00_0000, din};
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// 8-bit multiple-input signature register. A load takes priority over a
// compaction step so a session restart never absorbs a stale response.
module misr_compactor
    import bist_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       en,
    input  logic [1:0] din,
    output logic [7:0] sig
);

    // Signature register: reset value, reseed, or one compaction step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= misrStep(sig, din);
        end else begin
            sig <= sig;
        end
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// Output response analyzer for the full-adder BIST path: compacts the CUT's
// {cout, sum} responses into an MISR signature and compares it against a
// golden value at the end of each session.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int         SIG_W    = 8,
    parameter int         PATTERNS = 8,
    parameter logic [7:0] SEED     = 8'h00,
    parameter logic [7:0] GOLDEN   = DEFAULT_GOLDEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        resp_valid,
    input  logic [1:0]                  resp,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [SIG_W-1:0]            signature,
    output logic [$clog2(PATTERNS+1)-1:0] count
);

    localparam int CNT_W = $clog2(PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERNS - 1);

    bistState_e       state_r;
    bistState_e       stateNext_s;
    logic [CNT_W-1:0] countNext_s;
    logic             passNext_s;
    logic             misrLoad_s;
    logic             misrEn_s;
    logic [7:0]       sig_s;

    misr_compactor #(
        .RST_VAL (SEED)
    ) uMisr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (misrLoad_s),
        .seed  (SEED),
        .en    (misrEn_s),
        .din   (resp),
        .sig   (sig_s)
    );

    assign signature = sig_s;

    // Next-state, counter and compare decode for the session FSM
    always_comb begin
        stateNext_s = state_r;
        countNext_s = count;
        passNext_s  = pass;
        misrLoad_s  = 1'b0;
        misrEn_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    misrLoad_s  = 1'b1;
                    countNext_s = '0;
                    passNext_s  = 1'b0;
                    stateNext_s = ST_RUN;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    // restart: the coincident response is dropped
                    misrLoad_s  = 1'b1;
                    countNext_s = '0;
                    stateNext_s = ST_RUN;
                end else if (resp_valid) begin
                    misrEn_s    = 1'b1;
                    countNext_s = count + CNT_W'(1);
                    if (count == LAST_IDX) begin
                        stateNext_s = ST_CHECK;
                    end else begin
                        stateNext_s = ST_RUN;
                    end
                end else begin
                    stateNext_s = ST_RUN;
                end
            end
            ST_CHECK: begin
                passNext_s  = (sig_s == GOLDEN);
                stateNext_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    misrLoad_s  = 1'b1;
                    countNext_s = '0;
                    passNext_s  = 1'b0;
                    stateNext_s = ST_RUN;
                end else begin
                    stateNext_s = ST_DONE;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
                countNext_s = '0;
                passNext_s  = 1'b0;
            end
        endcase
    end

    // State, counter, result and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            count   <= '0;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            count   <= countNext_s;
            pass    <= passNext_s;
            busy    <= (stateNext_s == ST_RUN) || (stateNext_s == ST_CHECK);
            done    <= (stateNext_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench for bist_response_analyzer: expected signature/count are
// queued when each response is driven and compared after the capturing edge.
module tb_bist_response_analyzer;

    localparam int         PATTERNS = 8;
    localparam int         CNT_W    = $clog2(PATTERNS + 1);
    localparam logic [7:0] SEED     = 8'h00;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             resp_valid;
    logic [1:0]       resp;
    logic             busy, done, pass;
    logic [7:0]       signature;
    logic [CNT_W-1:0] count;

    logic             startFb, validFb;
    logic [1:0]       respFb;
    logic             busyFb, doneFb, passFb;
    logic [7:0]       sigFb;
    logic [0:0]       countFb;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [7:0] sig;
        int         cnt;
    } exp_t;
    exp_t       sbQ[$];
    logic [7:0] mSig;
    int         mCount;

    logic [1:0] goodSeq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [1:0] badSeq  [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2};
    logic [7:0] goodTrace [8] = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h10, 8'h22, 8'h47};

    bist_response_analyzer #(
        .SIG_W(8), .PATTERNS(PATTERNS), .SEED(SEED), .GOLDEN(8'h47)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .count(count)
    );

    bist_response_analyzer #(
        .SIG_W(8), .PATTERNS(1), .SEED(8'h80), .GOLDEN(8'h1D)
    ) dutFb (
        .clk(clk), .rst_n(rst_n), .start(startFb), .resp_valid(validFb), .resp(respFb),
        .busy(busyFb), .done(doneFb), .pass(passFb), .signature(sigFb), .count(countFb)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Polynomial division form of the MISR: 9-bit shift, reduce by x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] modelStep(input logic [7:0] cur, input logic [1:0] r);
        logic [8:0] t;
        t = {cur, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ {6'd0, r};
    endfunction

    // Called at a negedge; pulses start for one cycle and returns at a negedge
    task automatic doStart(input logic withValid, input logic [1:0] r);
        start = 1'b1; resp_valid = withValid; resp = r;
        mSig = SEED; mCount = 0;
        @(posedge clk); #1;
        start = 1'b0; resp_valid = 1'b0;
        checkVal("start_busy", busy, 1'b1);
        checkVal("start_sig", signature, SEED);
        checkVal("start_count", count, 0);
        @(negedge clk);
    endtask

    task automatic sendResp(input logic [1:0] r);
        exp_t e;
        resp_valid = 1'b1; resp = r;
        mSig = modelStep(mSig, r); mCount++;
        sbQ.push_back('{sig: mSig, cnt: mCount});
        @(posedge clk); #1;
        resp_valid = 1'b0;
        e = sbQ.pop_front();
        checkVal("resp_sig", signature, e.sig);
        checkVal("resp_count", count, e.cnt);
        @(negedge clk);
    endtask

    task automatic gap(input int n, input int expCnt);
        for (int i = 0; i < n; i++) begin
            resp_valid = 1'b0; resp = 2'd3;
            @(posedge clk); #1;
            checkVal("gap_count", count, expCnt);
            checkVal("gap_sig", signature, mSig);
            @(negedge clk);
        end
    endtask

    // Entered at the negedge after the last response (state CHECK)
    task automatic finishCheck(input logic expPass, input logic checkStartIgnored);
        checkVal("check_busy", busy, 1'b1);
        checkVal("check_done", done, 1'b0);
        start = checkStartIgnored;
        @(posedge clk); #1;
        start = 1'b0;
        checkVal("done_flag", done, 1'b1);
        checkVal("done_busy", busy, 1'b0);
        checkVal("done_pass", pass, expPass);
        checkVal("done_sig", signature, mSig);
        checkVal("done_count", count, PATTERNS);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp = 2'd0;
        startFb = 1'b0; validFb = 1'b0; respFb = 2'd0;
        mSig = SEED; mCount = 0;
        #1;
        checkVal("rst_busy", busy, 1'b0);
        checkVal("rst_done", done, 1'b0);
        checkVal("rst_pass", pass, 1'b0);
        checkVal("rst_sig", signature, 8'h00);
        checkVal("rst_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free session with explicit signature trace
        doStart(1'b0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            sendResp(goodSeq[i]);
            checkVal("trace_sig", signature, goodTrace[i]);
        end
        finishCheck(1'b1, 1'b0);
        checkVal("golden_sig", signature, 8'h47);
        // DONE holds while resp_valid toggles
        resp_valid = 1'b1; resp = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        resp_valid = 1'b0;
        checkVal("hold_sig", signature, 8'h47);
        checkVal("hold_done", done, 1'b1);
        checkVal("hold_pass", pass, 1'b1);
        @(negedge clk);

        // Stuck-at on sum; start during CHECK must be ignored
        doStart(1'b0, 2'd0);
        for (int i = 0; i < 8; i++) sendResp(badSeq[i]);
        checkVal("fault_sig_differs", (signature != 8'h47), 1'b1);
        finishCheck(1'b0, 1'b1);

        // Gapped valid
        doStart(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) sendResp(goodSeq[i]);
        gap(3, 4);
        for (int i = 4; i < 8; i++) sendResp(goodSeq[i]);
        finishCheck(1'b1, 1'b0);
        checkVal("gap_final_sig", signature, 8'h47);

        // Restart mid-session; coincident response discarded
        doStart(1'b0, 2'd0);
        for (int i = 0; i < 5; i++) sendResp(goodSeq[i]);
        doStart(1'b1, 2'd3);
        for (int i = 0; i < 8; i++) sendResp(goodSeq[i]);
        finishCheck(1'b1, 1'b0);

        // Async reset mid-session, then IDLE ignores resp_valid
        doStart(1'b0, 2'd0);
        for (int i = 0; i < 3; i++) sendResp(goodSeq[i]);
        #2 rst_n = 1'b0;
        #1;
        checkVal("arst_sig", signature, 8'h00);
        checkVal("arst_count", count, 0);
        checkVal("arst_busy", busy, 1'b0);
        checkVal("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp = 2'd3;
            @(posedge clk); #1;
            checkVal("idle_sig", signature, 8'h00);
            checkVal("idle_count", count, 0);
            checkVal("idle_busy", busy, 1'b0);
            @(negedge clk);
        end
        resp_valid = 1'b0;

        // Feedback path: seed 80, one response 0
        startFb = 1'b1;
        @(posedge clk); #1;
        startFb = 1'b0;
        checkVal("fb_seed", sigFb, 8'h80);
        checkVal("fb_busy", busyFb, 1'b1);
        @(negedge clk);
        validFb = 1'b1; respFb = 2'd0;
        @(posedge clk); #1;
        validFb = 1'b0;
        checkVal("fb_sig", sigFb, 8'h1D);
        checkVal("fb_model", sigFb, modelStep(8'h80, 2'd0));
        checkVal("fb_count", countFb, 1);
        @(posedge clk); #1;
        checkVal("fb_done", doneFb, 1'b1);
        checkVal("fb_pass", passFb, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
